// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle MIPS controller.
// State encoding, opcode/funct values, ALU codes and mux selects.
package multicycle_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEX   = 4'd9,
      S_ADDIWB   = 4'd10,
      S_GPIOWB   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_SLT = 6'h2A;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   localparam logic [1:0] DST_RT = 2'd0;
   localparam logic [1:0] DST_RD = 2'd1;
   localparam logic [1:0] DST_RA = 2'd2;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_MEM  = 2'd1;
   localparam logic [1:0] WB_GPIO = 2'd2;

   localparam logic SRCA_PC = 1'b0;
   localparam logic SRCA_A  = 1'b1;

   localparam logic [1:0] SRCB_B       = 2'd0;
   localparam logic [1:0] SRCB_FOUR    = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   // One bundle of every strobe the FSM produces in a state.
   typedef struct packed {
      logic       pc_en;
      logic       i_or_d;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic       illegal_op;
      logic       alu_en;
      alu_op_t    alu_op;
   } ctrl_t;

   function automatic logic is_mem_op(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/multicycle_if.sv
// Point-to-point wires between the controller and the datapath.
// master = controller side, slave = datapath side.
interface multicycle_if;

   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Zero;
   logic       PC_En;
   logic       I_or_D;
   logic       Mem_Write;
   logic       IR_Write;
   logic [1:0] Reg_Dst;
   logic [1:0] Mem_to_Reg;
   logic       Reg_Write;
   logic       ALU_Src_A;
   logic [1:0] ALU_Src_B;
   logic [2:0] ALU_Control;
   logic [1:0] PC_Src;
   logic       Illegal_Op;
   logic [3:0] State_o;

   modport master (
      input  Op, Funct, Zero,
      output PC_En, I_or_D, Mem_Write, IR_Write,
      output Reg_Dst, Mem_to_Reg, Reg_Write,
      output ALU_Src_A, ALU_Src_B, ALU_Control,
      output PC_Src, Illegal_Op, State_o
   );

   modport slave (
      output Op, Funct, Zero,
      input  PC_En, I_or_D, Mem_Write, IR_Write,
      input  Reg_Dst, Mem_to_Reg, Reg_Write,
      input  ALU_Src_A, ALU_Src_B, ALU_Control,
      input  PC_Src, Illegal_Op, State_o
   );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Maps the controller's ALU_Op request and the funct field to an ALU code.
// Funct_Valid flags the R-type functs the datapath supports.
module alu_decoder
   import multicycle_pkg::*;
(
   input  alu_op_t    ALU_Op,
   input  logic [5:0] Funct,
   output logic [2:0] ALU_Control,
   output logic       Funct_Valid
);

   logic [2:0] funct_ctrl;

   // Funct lookup, then select by requested operation.
   always_comb begin
      funct_ctrl  = ALU_ADD;
      Funct_Valid = 1'b1;
      unique case (Funct)
         F_ADD:   funct_ctrl = ALU_ADD;
         F_SUB:   funct_ctrl = ALU_SUB;
         F_AND:   funct_ctrl = ALU_AND;
         F_OR:    funct_ctrl = ALU_OR;
         F_SLT:   funct_ctrl = ALU_SLT;
         default: Funct_Valid = 1'b0;
      endcase

      unique case (ALU_Op)
         ALUOP_ADD:   ALU_Control = ALU_ADD;
         ALUOP_SUB:   ALU_Control = ALU_SUB;
         ALUOP_FUNCT: ALU_Control = funct_ctrl;
         default:     ALU_Control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencing FSM for the multicycle MIPS datapath.
// Optional gpin instruction enabled by defining MULTICYCLE_GPIO_IN_EN.
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter logic [5:0] GPIO_IN_OPCODE = 6'h3F
) (
   input  logic          clk,
   input  logic          reset,
   multicycle_if.master  ctl
);

   state_t     state_q, state_d;
   ctrl_t      c, co;
   logic [2:0] alu_ctrl;
   logic       funct_valid;

   alu_decoder u_alu_dec (
      .ALU_Op      (c.alu_op),
      .Funct       (ctl.Funct),
      .ALU_Control (alu_ctrl),
      .Funct_Valid (funct_valid)
   );

   // State register, forced to FETCH while reset is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Next state and per-state strobes.
   always_comb begin
      c        = '0;
      c.alu_op = ALUOP_ADD;
      state_d  = state_q;
      unique case (state_q)
         S_FETCH: begin
            c.ir_write  = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.alu_en    = 1'b1;
            c.pc_src    = PCSRC_ALU;
            c.pc_en     = 1'b1;
            state_d     = S_DECODE;
         end
         S_DECODE: begin
            c.alu_src_b = SRCB_IMM_SL2;
            c.alu_en    = 1'b1;
            state_d     = S_FETCH;
            if (ctl.Op == OP_J) begin
               c.pc_src = PCSRC_JUMP;
               c.pc_en  = 1'b1;
            end else if (ctl.Op == OP_JAL) begin
               // ALU_Out still holds PC+4, which is the link value.
               c.pc_src     = PCSRC_JUMP;
               c.pc_en      = 1'b1;
               c.reg_write  = 1'b1;
               c.reg_dst    = DST_RA;
               c.mem_to_reg = WB_ALU;
            end else if (is_mem_op(ctl.Op)) begin
               state_d = S_MEMADR;
            end else if (ctl.Op == OP_RTYPE && funct_valid) begin
               state_d = S_EXECUTE;
            end else if (ctl.Op == OP_BEQ || ctl.Op == OP_BNE) begin
               state_d = S_BRANCH;
            end else if (ctl.Op == OP_ADDI) begin
               state_d = S_ADDIEX;
`ifdef MULTICYCLE_GPIO_IN_EN
            end else if (ctl.Op == GPIO_IN_OPCODE) begin
               state_d = S_GPIOWB;
`else
            end else if (ctl.Op == GPIO_IN_OPCODE) begin
               // gpin is not built in; it traps like any unknown opcode.
               c.illegal_op = 1'b1;
`endif
            end else begin
               c.illegal_op = 1'b1;
            end
         end
         S_MEMADR: begin
            c.alu_src_a = SRCA_A;
            c.alu_src_b = SRCB_IMM;
            c.alu_en    = 1'b1;
            state_d     = (ctl.Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            c.i_or_d = 1'b1;
            state_d  = S_MEMWB;
         end
         S_MEMWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = WB_MEM;
            c.reg_dst    = DST_RT;
            state_d      = S_FETCH;
         end
         S_MEMWRITE: begin
            c.i_or_d    = 1'b1;
            c.mem_write = 1'b1;
            state_d     = S_FETCH;
         end
         S_EXECUTE: begin
            c.alu_src_a = SRCA_A;
            c.alu_src_b = SRCB_B;
            c.alu_op    = ALUOP_FUNCT;
            c.alu_en    = 1'b1;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            c.reg_write  = 1'b1;
            c.reg_dst    = DST_RD;
            c.mem_to_reg = WB_ALU;
            state_d      = S_FETCH;
         end
         S_BRANCH: begin
            c.alu_src_a = SRCA_A;
            c.alu_src_b = SRCB_B;
            c.alu_op    = ALUOP_SUB;
            c.alu_en    = 1'b1;
            c.pc_src    = PCSRC_ALUOUT;
            c.pc_en     = (ctl.Op == OP_BEQ) ? ctl.Zero : !ctl.Zero;
            state_d     = S_FETCH;
         end
         S_ADDIEX: begin
            c.alu_src_a = SRCA_A;
            c.alu_src_b = SRCB_IMM;
            c.alu_en    = 1'b1;
            state_d     = S_ADDIWB;
         end
         S_ADDIWB: begin
            c.reg_write  = 1'b1;
            c.reg_dst    = DST_RT;
            c.mem_to_reg = WB_ALU;
            state_d      = S_FETCH;
         end
         S_GPIOWB: begin
`ifdef MULTICYCLE_GPIO_IN_EN
            c.reg_write  = 1'b1;
            c.reg_dst    = DST_RT;
            c.mem_to_reg = WB_GPIO;
`endif
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Gate every strobe with reset so an aborted write dies immediately.
   always_comb begin
      co = reset ? c : '0;
   end

   assign ctl.PC_En       = co.pc_en;
   assign ctl.I_or_D      = co.i_or_d;
   assign ctl.Mem_Write   = co.mem_write;
   assign ctl.IR_Write    = co.ir_write;
   assign ctl.Reg_Dst     = co.reg_dst;
   assign ctl.Mem_to_Reg  = co.mem_to_reg;
   assign ctl.Reg_Write   = co.reg_write;
   assign ctl.ALU_Src_A   = co.alu_src_a;
   assign ctl.ALU_Src_B   = co.alu_src_b;
   assign ctl.ALU_Control = co.alu_en ? alu_ctrl : 3'b000;
   assign ctl.PC_Src      = co.pc_src;
   assign ctl.Illegal_Op  = co.illegal_op;
   assign ctl.State_o     = reset ? state_q : S_FETCH;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control.
// Walks each instruction class through its state sequence.
module tb_multicycle_control;
   import multicycle_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   multicycle_if bus ();

   multicycle_control #(
      .GPIO_IN_OPCODE (6'h3F)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .ctl   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_state(input string tag, input logic [3:0] exp);
      @(negedge clk);
      #1;
      check(tag, 32'(bus.State_o), 32'(exp));
   endtask

   initial begin
      bus.Op    = OP_LW;
      bus.Funct = 6'h00;
      bus.Zero  = 1'b0;
      #12;
      check("rst_state", 32'(bus.State_o), 0);
      check("rst_irw", 32'(bus.IR_Write), 0);
      check("rst_pcen", 32'(bus.PC_En), 0);
      check("rst_aluc", 32'(bus.ALU_Control), 0);

      // lw: 0,1,2,3,4,0
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("f_state", 32'(bus.State_o), 0);
      check("f_irw", 32'(bus.IR_Write), 1);
      check("f_pcen", 32'(bus.PC_En), 1);
      check("f_srcb", 32'(bus.ALU_Src_B), 1);
      check("f_aluc", 32'(bus.ALU_Control), 3'b010);
      expect_state("lw_s1", 1);
      check("d_srcb", 32'(bus.ALU_Src_B), 3);
      check("d_pcen", 32'(bus.PC_En), 0);
      expect_state("lw_s2", 2);
      check("ma_srca", 32'(bus.ALU_Src_A), 1);
      check("ma_srcb", 32'(bus.ALU_Src_B), 2);
      expect_state("lw_s3", 3);
      check("mr_iord", 32'(bus.I_or_D), 1);
      check("mr_rw", 32'(bus.Reg_Write), 0);
      expect_state("lw_s4", 4);
      check("mwb_rw", 32'(bus.Reg_Write), 1);
      check("mwb_m2r", 32'(bus.Mem_to_Reg), 1);
      expect_state("lw_s0", 0);

      // R-type sub: 0,1,6,7,0
      bus.Op    = OP_RTYPE;
      bus.Funct = F_SUB;
      expect_state("r_s1", 1);
      expect_state("r_s6", 6);
      check("ex_aluc", 32'(bus.ALU_Control), 3'b110);
      check("ex_srca", 32'(bus.ALU_Src_A), 1);
      check("ex_srcb", 32'(bus.ALU_Src_B), 0);
      expect_state("r_s7", 7);
      check("awb_dst", 32'(bus.Reg_Dst), 1);
      check("awb_rw", 32'(bus.Reg_Write), 1);
      check("awb_aluc", 32'(bus.ALU_Control), 0);
      expect_state("r_s0", 0);

      // beq taken
      bus.Op   = OP_BEQ;
      bus.Zero = 1'b1;
      expect_state("beq_s1", 1);
      expect_state("beq_s8", 8);
      check("beq_pcen", 32'(bus.PC_En), 1);
      check("beq_pcsrc", 32'(bus.PC_Src), 1);
      check("beq_aluc", 32'(bus.ALU_Control), 3'b110);
      expect_state("beq_s0", 0);

      // bne with Zero=1 then Zero=0
      bus.Op = OP_BNE;
      expect_state("bne_s1", 1);
      expect_state("bne_s8", 8);
      check("bne_z1_pcen", 32'(bus.PC_En), 0);
      bus.Zero = 1'b0;
      #1;
      check("bne_z0_pcen", 32'(bus.PC_En), 1);
      expect_state("bne_s0", 0);

      // jal
      bus.Op = OP_JAL;
      expect_state("jal_s1", 1);
      check("jal_dst", 32'(bus.Reg_Dst), 2);
      check("jal_rw", 32'(bus.Reg_Write), 1);
      check("jal_pcsrc", 32'(bus.PC_Src), 2);
      check("jal_pcen", 32'(bus.PC_En), 1);
      check("jal_m2r", 32'(bus.Mem_to_Reg), 0);
      expect_state("jal_s0", 0);

      // addi: 0,1,9,10,0
      bus.Op = OP_ADDI;
      expect_state("addi_s1", 1);
      expect_state("addi_s9", 9);
      check("aex_srcb", 32'(bus.ALU_Src_B), 2);
      expect_state("addi_s10", 10);
      check("awb2_rw", 32'(bus.Reg_Write), 1);
      check("awb2_dst", 32'(bus.Reg_Dst), 0);
      expect_state("addi_s0", 0);

      // gpin opcode
      bus.Op = 6'h3F;
      expect_state("gp_s1", 1);
`ifdef MULTICYCLE_GPIO_IN_EN
      check("gp_ill", 32'(bus.Illegal_Op), 0);
      expect_state("gp_s11", 11);
      check("gp_m2r", 32'(bus.Mem_to_Reg), 2);
      check("gp_rw", 32'(bus.Reg_Write), 1);
`else
      check("gp_ill", 32'(bus.Illegal_Op), 1);
      check("gp_rw", 32'(bus.Reg_Write), 0);
      check("gp_pcen", 32'(bus.PC_En), 0);
`endif
      expect_state("gp_s0", 0);
      check("gp_ill_end", 32'(bus.Illegal_Op), 0);

      // unsupported funct
      bus.Op    = OP_RTYPE;
      bus.Funct = 6'h21;
      expect_state("bf_s1", 1);
      check("bf_ill", 32'(bus.Illegal_Op), 1);
      expect_state("bf_s0", 0);
      check("bf_ill_end", 32'(bus.Illegal_Op), 0);

      // sw aborted by reset in MEMWRITE
      bus.Op = OP_SW;
      expect_state("sw_s1", 1);
      expect_state("sw_s2", 2);
      expect_state("sw_s5", 5);
      check("sw_mw", 32'(bus.Mem_Write), 1);
      check("sw_iord", 32'(bus.I_or_D), 1);
      #2;
      reset = 1'b0;
      #1;
      check("abort_mw", 32'(bus.Mem_Write), 0);
      check("abort_state", 32'(bus.State_o), 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rel_state", 32'(bus.State_o), 0);
      check("rel_irw", 32'(bus.IR_Write), 1);
      expect_state("rel_s1", 1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multicycle MIPS datapath. Each cycle it decodes the registered opcode/funct fields and the datapath `Zero` flag into every datapath control strobe: PC enable, memory/IR write, register-file write, mux selects and ALU operation. It sits beside the datapath in the CPU top level, with all control wires point-to-point.

## Interface
- `GPIO_IN_OPCODE`, default 6'h3F: opcode of the custom `gpin rt` instruction (used only when `GPIO_IN_EN` is defined).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Op`  in  6  `Instr[31:26]` from the IR.
- `Funct`  in  6  `Instr[5:0]` from the IR.
- `Zero`  in  1  high when the combinational ALU result is 0.
- `PC_En`  out  1  PC load.
- `I_or_D`  out  1  0 = PC address, 1 = ALU_Out address.
- `Mem_Write`  out  1  memory write strobe.
- `IR_Write`  out  1  IR load.
- `Reg_Dst`  out  2  0 = rt, 1 = rd, 2 = $31.
- `Mem_to_Reg`  out  2  0 = ALU_Out, 1 = Data, 2 = GPIO_i.
- `Reg_Write`  out  1  register-file write.
- `ALU_Src_A`  out  1  0 = PC, 1 = A.
- `ALU_Src_B`  out  2  0 = B, 1 = 4, 2 = SignImm, 3 = SignImm<<2.
- `ALU_Control`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `PC_Src`  out  2  0 = ALU_Result, 1 = ALU_Out, 2 = jump target.
- `Illegal_Op`  out  1  one-cycle pulse in DECODE for an unsupported opcode/funct.
- `State_o`  out  4  current state, for debug.

## Operation
- Moore FSM. DECODE outputs also depend on `Op`, which is stable because the IR is registered. Unlisted outputs are 0 in every state.
- FETCH: `IR_Write`=1, `ALU_Src_B`=1, add, `PC_Src`=0, `PC_En`=1. Next state is DECODE.
- DECODE: `ALU_Src_B`=3, add, so ALU_Out receives the branch target. ALU_Out still holds PC+4 during this cycle.
  - j: `PC_Src`=2, `PC_En`=1, then FETCH.
  - jal: as j, plus `Reg_Write`=1, `Reg_Dst`=2, `Mem_to_Reg`=0; the link value is PC+4. Then FETCH.
  - lw/sw (23/2B): MEMADR.
  - R-type (00) with funct in {20,22,24,25,2A}: EXECUTE.
  - beq/bne (04/05): BRANCH.
  - addi (08): ADDIEX.
  - anything else: `Illegal_Op`=1, no write, then FETCH.
- MEMADR: `ALU_Src_A`=1, `ALU_Src_B`=2, add. Next is MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: `I_or_D`=1, then MEMWB.
- MEMWB: `Reg_Write`=1, `Mem_to_Reg`=1, `Reg_Dst`=0, then FETCH.
- MEMWRITE: `I_or_D`=1, `Mem_Write`=1, then FETCH.
- EXECUTE: `ALU_Src_A`=1, `ALU_Src_B`=0, ALU operation taken from funct, then ALUWB.
- ALUWB: `Reg_Write`=1, `Reg_Dst`=1, `Mem_to_Reg`=0, then FETCH.
- BRANCH: `ALU_Src_A`=1, `ALU_Src_B`=0, sub, `PC_Src`=1. `PC_En` = `Zero` for beq, `!Zero` for bne. Then FETCH.
- ADDIEX: `ALU_Src_A`=1, `ALU_Src_B`=2, add, then ADDIWB.
- ADDIWB: `Reg_Write`=1, `Reg_Dst`=0, `Mem_to_Reg`=0, then FETCH.

## Timing
- Cycles per instruction, counted from FETCH entry: j/jal 2, illegal 2, beq/bne 3, R-type 4, addi 4, sw 4, lw 5, gpin 3.
- While `reset` is low:
  - the state register is asynchronously forced to FETCH;
  - every output is gated to 0;
  - `State_o` reads 0 (FETCH).
- The first active edge after reset release ends the first FETCH.
- Reset asserted mid-instruction aborts it immediately. No partial write may occur after assertion.
- `Illegal_Op` is high for exactly one cycle, never in back-to-back cycles.

## Configuration
- `MULTICYCLE_GPIO_IN_EN` defined: DECODE maps `Op`==`GPIO_IN_OPCODE` to GPIOWB (state 11). GPIOWB drives `Reg_Write`=1, `Reg_Dst`=0, `Mem_to_Reg`=2, then FETCH.
- Not defined: that opcode is illegal and `Mem_to_Reg` never equals 2.

## Structure
- Shared package `multicycle_pkg`:
  - state encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, GPIOWB 11;
  - opcode and funct constants;
  - ALU_Control codes;
  - mux-select constants.
- One sub-module, `alu_decoder`:
  - inputs: 2-bit ALU_Op (00 add, 01 sub, 10 funct) and `Funct`;
  - funct map: 20→010, 22→110, 24→000, 25→001, 2A→111;
  - output: `ALU_Control` plus a `Funct_Valid` flag.

## Test plan
- Release reset and hold `Op`=23 (lw) → states 0,1,2,3,4,0. In state 3 `I_or_D`=1; in state 4 `Reg_Write`=1 and `Mem_to_Reg`=1.
- `Op`=00, `Funct`=22 → EXECUTE with `ALU_Control`=110, then ALUWB with `Reg_Dst`=1; 4 cycles total.
- beq with `Zero`=1 → `PC_En`=1 and `PC_Src`=1 in BRANCH. bne with `Zero`=1 → `PC_En`=0.
- jal → DECODE drives `Reg_Dst`=2, `Reg_Write`=1, `PC_Src`=2, `PC_En`=1; back in FETCH the next cycle.
- `Op`=3F → with the macro, GPIOWB with `Mem_to_Reg`=2; without it, `Illegal_Op` pulses once and no `Reg_Write` occurs.
- Pull `reset` low during MEMWRITE → `Mem_Write` drops to 0 in the same cycle; `State_o`=0 after release.
